// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin burst arbiter driving a 4:1 select with a registered valid/ready output stage.
module mux_sel_arbiter #(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [3:0]    last,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_state_nxt;
  logic [1:0] r_sel, r_ptr, w_sel_nxt, w_ptr_nxt, w_base, w_off, w_win;
  logic [3:0] r_gnt, w_gnt_nxt, r_beat_cnt, w_beat_nxt, w_rot;
  logic r_out_valid, w_can_load, w_xfer, w_release, w_any;
  logic [DW-1:0] r_out_data;
  assign w_can_load = !r_out_valid || out_ready;
  assign w_xfer     = (r_state == GRANT) && req[r_sel] && w_can_load;
  assign w_release  = (r_state == GRANT) &&
                      (!req[r_sel] || (w_xfer && (last[r_sel] || r_beat_cnt == 4'(HOLD_MAX - 1))));
  // On release the search starts just past the old owner, making it lowest priority.
  assign w_base = w_release ? r_sel + 2'd1 : r_ptr;
  assign w_rot  = 4'({req, req} >> w_base);
  assign w_off  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign w_win  = w_base + w_off;
  assign w_any  = |req;
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_beat_nxt  = r_beat_cnt;
    w_ptr_nxt   = w_release ? w_base : r_ptr;
    if (r_state == IDLE || w_release) begin
      w_state_nxt = w_any ? GRANT : IDLE;
      w_gnt_nxt   = w_any ? 4'b0001 << w_win : 4'b0000;
      w_sel_nxt   = w_any ? w_win : r_sel;
      w_beat_nxt  = 4'd0;
    end else if (w_xfer) begin
      w_beat_nxt = r_beat_cnt + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= 2'd0;
      r_ptr       <= 2'd0;
      r_gnt       <= 4'd0;
      r_beat_cnt  <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (w_xfer) begin
        r_out_data  <= in_data[r_sel*DW +: DW];
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
endmodule
